wb_arbiter: RTL and testbench

Round-robin arbiter sharing one pipelined Wishbone slave port among Count masters. It sits upstream of wb_multiplexer, so several bus masters (e.g. CPU fetch, CPU data, DMA) can reach the decoded slave fabric. A grant is held for a master's whole cycle (m_cyc high). Grant changes only between cycles.

---
 rtl/wb_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_wb_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin arbiter that shares one pipelined Wishbone slave port among
// Count masters. A grant covers a master's whole m_cyc cycle. There is always at least
// one IDLE cycle between two grants.
//
// Optional feature macro: WB_ARBITER_TIMEOUT_EN. When it is defined, a grant that waits
// Timeout cycles with outstanding beats and no response is aborted with m_err.
//
// Ports:
//   clk, reset                  clock (rising edge), asynchronous active-high reset
//   m_data_m/m_addr/m_sel       per-master write data, address and byte select
//   m_cyc/m_stb/m_we            per-master cycle, strobe and write enable
//   m_data_s                    read data, s_data_s broadcast to every master
//   m_ack/m_err                 responses, routed to the granted master only
//   m_stall                     granted master gets s_stall; all others see 1
//   s_data_m..s_we              slave-side copies of the granted master's signals
//   s_data_s/s_ack/s_stall/s_err slave responses
module wb_arbiter #(
    parameter int unsigned Count     = 2,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned Timeout   = 255,
    localparam int unsigned SelWidth = DataWidth / 8,
    localparam int unsigned TagWidth = (Count > 1) ? $clog2(Count) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [Count-1:0][DataWidth-1:0]   m_data_m,
    input  logic [Count-1:0][AddrWidth-1:0]   m_addr,
    input  logic [Count-1:0][SelWidth-1:0]    m_sel,
    input  logic [Count-1:0]                  m_cyc,
    input  logic [Count-1:0]                  m_stb,
    input  logic [Count-1:0]                  m_we,
    output logic [Count-1:0][DataWidth-1:0]   m_data_s,
    output logic [Count-1:0]                  m_ack,
    output logic [Count-1:0]                  m_stall,
    output logic [Count-1:0]                  m_err,
    output logic [DataWidth-1:0]              s_data_m,
    output logic [AddrWidth-1:0]              s_addr,
    output logic [SelWidth-1:0]               s_sel,
    output logic                              s_cyc,
    output logic                              s_stb,
    output logic                              s_we,
    input  logic [DataWidth-1:0]              s_data_s,
    input  logic                              s_ack,
    input  logic                              s_stall,
    input  logic                              s_err
);

    localparam int unsigned OutWidth = $clog2(Timeout + 1) + 1;

    typedef enum logic [0:0] {StIdle, StGranted} state_e;

    state_e                state_q, state_d;
    logic [TagWidth-1:0]   gnt_q, gnt_d;
    logic [TagWidth-1:0]   rr_ptr_q, rr_ptr_d;
    logic [OutWidth-1:0]   outstanding_q, outstanding_d;
    logic [TagWidth-1:0]   next_ptr;
    logic [TagWidth-1:0]   winner;
    logic                  found;
    logic                  abort;
    logic                  accept;
    logic                  resp;

    // First requester searching from rr_ptr upwards, wrapping at Count.
    always_comb begin
        logic [TagWidth:0] sum;
        found  = 1'b0;
        winner = '0;
        sum    = '0;
        for (int unsigned i = 0; i < Count; i++) begin
            sum = {1'b0, rr_ptr_q} + (TagWidth + 1)'(i);
            if (sum >= (TagWidth + 1)'(Count)) begin
                sum = sum - (TagWidth + 1)'(Count);
            end
            if (!found && m_cyc[sum[TagWidth-1:0]]) begin
                found  = 1'b1;
                winner = sum[TagWidth-1:0];
            end
        end
    end

    assign next_ptr = (gnt_q == TagWidth'(Count - 1)) ? '0 : gnt_q + TagWidth'(1);

`ifdef WB_ARBITER_TIMEOUT_EN
    localparam int unsigned WaitWidth = $clog2(Timeout + 1);

    logic [WaitWidth-1:0] wait_q, wait_d;
    logic                 wait_clr;

    // Any response or newly accepted beat counts as progress and restarts the wait.
    assign wait_clr = s_ack || s_err || (m_stb[gnt_q] && !s_stall);

    // Fires in the Timeout-th consecutive cycle without progress.
    assign abort = (state_q == StGranted) && m_cyc[gnt_q] && (outstanding_q != '0) &&
                   !wait_clr && (wait_q == WaitWidth'(Timeout - 1));

    always_comb begin
        wait_d = '0;
        if ((state_q == StGranted) && (outstanding_q != '0) && !wait_clr) begin
            wait_d = wait_q + WaitWidth'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    logic unused_outstanding;

    assign abort              = 1'b0;
    assign unused_outstanding = ^outstanding_q;
`endif

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        rr_ptr_d      = rr_ptr_q;
        outstanding_d = outstanding_q;
        s_cyc         = 1'b0;
        s_stb         = 1'b0;
        s_we          = 1'b0;
        s_addr        = '0;
        s_sel         = '0;
        s_data_m      = '0;
        m_stall       = '1;
        m_ack         = '0;
        m_err         = '0;
        accept        = 1'b0;
        resp          = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    gnt_d   = winner;
                    state_d = StGranted;
                end
            end
            StGranted: begin
                s_cyc          = m_cyc[gnt_q] && !abort;
                s_stb          = m_stb[gnt_q] && !abort;
                s_we           = m_we[gnt_q];
                s_addr         = m_addr[gnt_q];
                s_sel          = m_sel[gnt_q];
                s_data_m       = m_data_m[gnt_q];
                m_stall[gnt_q] = s_stall || abort;
                m_ack[gnt_q]   = s_ack;
                m_err[gnt_q]   = s_err || abort;

                accept = s_stb && !s_stall;
                resp   = s_ack || s_err;

                if (!m_cyc[gnt_q] || abort) begin
                    state_d       = StIdle;
                    rr_ptr_d      = next_ptr;
                    outstanding_d = '0;
                end else if (accept && !resp) begin
                    outstanding_d = outstanding_q + OutWidth'(1);
                end else if (!accept && resp && (outstanding_q != '0)) begin
                    outstanding_d = outstanding_q - OutWidth'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        for (int unsigned i = 0; i < Count; i++) begin
            m_data_s[i] = s_data_s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            gnt_q         <= '0;
            rr_ptr_q      <= '0;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            rr_ptr_q      <= rr_ptr_d;
            outstanding_q <= outstanding_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = DW / 8;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [N-1:0][DW-1:0] m_data_m;
    logic [N-1:0][AW-1:0] m_addr;
    logic [N-1:0][SW-1:0] m_sel;
    logic [N-1:0]         m_cyc, m_stb, m_we;
    logic [N-1:0][DW-1:0] m_data_s;
    logic [N-1:0]         m_ack, m_stall, m_err;
    logic [DW-1:0]        s_data_m, s_data_s;
    logic [AW-1:0]        s_addr;
    logic [SW-1:0]        s_sel;
    logic                 s_cyc, s_stb, s_we, s_ack, s_stall, s_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_arbiter #(
        .Count     (N),
        .DataWidth (DW),
        .AddrWidth (AW),
        .Timeout   (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .m_data_m (m_data_m),
        .m_addr   (m_addr),
        .m_sel    (m_sel),
        .m_cyc    (m_cyc),
        .m_stb    (m_stb),
        .m_we     (m_we),
        .m_data_s (m_data_s),
        .m_ack    (m_ack),
        .m_stall  (m_stall),
        .m_err    (m_err),
        .s_data_m (s_data_m),
        .s_addr   (s_addr),
        .s_sel    (s_sel),
        .s_cyc    (s_cyc),
        .s_stb    (s_stb),
        .s_we     (s_we),
        .s_data_s (s_data_s),
        .s_ack    (s_ack),
        .s_stall  (s_stall),
        .s_err    (s_err)
    );

    task automatic clear_inputs();
        m_data_m = '0; m_addr = '0; m_sel = '0;
        m_cyc = '0; m_stb = '0; m_we = '0;
        s_data_s = '0; s_ack = 1'b0; s_stall = 1'b0; s_err = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        m_cyc = '1;
        m_stb = '1;
        #3 reset = 1'b1;
        #1;
        checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL reset_s_cyc got %b want 0", s_cyc); end
        checks++; if (s_stb !== 1'b0) begin errors++; $display("FAIL reset_s_stb got %b want 0", s_stb); end
        checks++; if (m_stall !== 2'b11) begin errors++; $display("FAIL reset_stall got %b want 11", m_stall); end
        checks++; if ({m_ack, m_err} !== 4'b0) begin errors++; $display("FAIL reset_ack_err got %b want 0000", {m_ack, m_err}); end
        tick();
        checks++; if (s_cyc !== 1'b0 || m_stall !== 2'b11) begin
            errors++; $display("FAIL reset_hold cyc=%b stall=%b want 0/11", s_cyc, m_stall);
        end
        reset = 1'b0;
        clear_inputs();
    endtask

    task automatic test_single_read();
        do_reset();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_addr[0] = 32'h100; m_sel[0] = 4'hF;
        #2;
        checks++; if (m_stall[0] !== 1'b1) begin errors++; $display("FAIL req_cycle_stall got %b want 1", m_stall[0]); end
        checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL req_cycle_s_cyc got %b want 0", s_cyc); end
        tick();
        #2;
        checks++; if (s_cyc !== 1'b1 || s_stb !== 1'b1) begin errors++; $display("FAIL grant_s_cyc got %b%b want 11", s_cyc, s_stb); end
        checks++; if (s_addr !== 32'h100) begin errors++; $display("FAIL grant_addr got %h want 100", s_addr); end
        checks++; if (m_stall !== 2'b10) begin errors++; $display("FAIL grant_stall got %b want 10", m_stall); end
        tick();
        m_stb[0] = 1'b0; s_ack = 1'b1; s_data_s = 32'hDEADBEEF;
        #2;
        checks++; if (m_ack !== 2'b01) begin errors++; $display("FAIL read_ack got %b want 01", m_ack); end
        checks++; if (m_data_s[0] !== 32'hDEADBEEF || m_data_s[1] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL read_data got %h/%h want deadbeef", m_data_s[0], m_data_s[1]);
        end
        tick();
        s_ack = 1'b0; m_cyc[0] = 1'b0;
        #2;
        checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL release_s_cyc got %b want 0", s_cyc); end
        tick();
    endtask

    task automatic test_contention();
        do_reset();
        m_addr[0] = 32'hA0; m_addr[1] = 32'hB0;
        m_cyc = 2'b11; m_stb = 2'b11;
        tick();
        s_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++; if (s_addr !== 32'hA0 || m_ack !== 2'b01 || m_stall !== 2'b10) begin
                errors++; $display("FAIL m0_first addr=%h ack=%b stall=%b want a0/01/10", s_addr, m_ack, m_stall);
            end
            tick();
        end
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        #2;
        checks++; if (s_cyc !== 1'b0 || m_stall[1] !== 1'b1) begin
            errors++; $display("FAIL m0_release cyc=%b stall1=%b want 0/1", s_cyc, m_stall[1]);
        end
        tick();
        #2;
        checks++; if (s_cyc !== 1'b0 || m_stall !== 2'b11 || m_ack !== 2'b00) begin
            errors++; $display("FAIL idle_gap cyc=%b stall=%b ack=%b want 0/11/00", s_cyc, m_stall, m_ack);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++; if (s_addr !== 32'hB0 || m_ack !== 2'b10 || m_stall !== 2'b01) begin
                errors++; $display("FAIL m1_second addr=%h ack=%b stall=%b want b0/10/01", s_addr, m_ack, m_stall);
            end
            tick();
        end
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0; s_ack = 1'b0;
        tick();
        m_cyc = 2'b11; m_stb = 2'b11;
        tick();
        #2;
        checks++; if (s_addr !== 32'hA0 || s_cyc !== 1'b1) begin
            errors++; $display("FAIL regrant_m0 addr=%h cyc=%b want a0/1", s_addr, s_cyc);
        end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_pipelined();
        int beats;
        do_reset();
        m_addr[1] = 32'hC0; m_cyc[1] = 1'b1;
        tick();
        beats = 0;
        for (int i = 0; i < 5; i++) begin
            m_stb[1] = 1'b1;
            s_stall = (i == 1);
            #2;
            checks++; if (m_stall[0] !== 1'b1 || m_stall[1] !== s_stall) begin
                errors++; $display("FAIL burst_stall got %b want %b1", m_stall, s_stall);
            end
            if (s_stb === 1'b1 && s_stall === 1'b0) beats++;
            tick();
        end
        m_stb[1] = 1'b0; s_stall = 1'b0;
        checks++; if (beats != 4) begin errors++; $display("FAIL burst_beats got %0d want 4", beats); end
        checks++; if (int'(dut.outstanding_q) != 4) begin
            errors++; $display("FAIL outstanding_peak got %0d want 4", dut.outstanding_q);
        end
        for (int i = 0; i < 4; i++) begin
            s_ack = 1'b1;
            #2;
            checks++; if (m_ack !== 2'b10) begin errors++; $display("FAIL burst_ack got %b want 10", m_ack); end
            tick();
        end
        s_ack = 1'b0;
        checks++; if (int'(dut.outstanding_q) != 0) begin
            errors++; $display("FAIL outstanding_drain got %0d want 0", dut.outstanding_q);
        end
        m_cyc[1] = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_late_ack();
        do_reset();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        tick();
        tick();
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        #2;
        checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL drop_same_cycle got %b want 0", s_cyc); end
        tick();
        s_ack = 1'b1;
        #2;
        checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL late_ack got %b want 00", m_ack); end
        tick();
        s_ack = 1'b0;
    endtask

    task automatic test_midburst_reset();
        do_reset();
        m_addr[0] = 32'hE0; m_addr[1] = 32'hF0;
        m_cyc[0] = 1'b1;
        tick();
        tick();
        m_cyc[0] = 1'b0;
        tick();
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        tick();
        #2;
        checks++; if (s_cyc !== 1'b1 || s_addr !== 32'hF0) begin
            errors++; $display("FAIL pre_reset_grant cyc=%b addr=%h want 1/f0", s_cyc, s_addr);
        end
        reset = 1'b1;
        #1;
        checks++; if (s_cyc !== 1'b0 || m_stall !== 2'b11) begin
            errors++; $display("FAIL async_reset cyc=%b stall=%b want 0/11", s_cyc, m_stall);
        end
        tick();
        reset = 1'b0;
        m_cyc = 2'b11; m_stb = 2'b11;
        tick();
        #2;
        checks++; if (s_addr !== 32'hE0) begin errors++; $display("FAIL rr_after_reset addr=%h want e0", s_addr); end
        clear_inputs();
        tick();
        tick();
    endtask

`ifdef WB_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        m_addr[0] = 32'h10; m_addr[1] = 32'h20;
        m_cyc = 2'b11; m_stb[0] = 1'b1;
        tick();
        #2;
        checks++; if (s_addr !== 32'h10 || s_stb !== 1'b1) begin
            errors++; $display("FAIL to_grant addr=%h stb=%b want 10/1", s_addr, s_stb);
        end
        tick();
        m_stb[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            #2;
            checks++; if (m_err !== ((k == 8) ? 2'b01 : 2'b00)) begin
                errors++; $display("FAIL to_err cycle %0d got %b", k, m_err);
            end
            if (k == 8) begin
                checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL to_abort_cyc got %b want 0", s_cyc); end
            end
            tick();
        end
        #2;
        checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL to_idle got %b want 0", s_cyc); end
        tick();
        #2;
        checks++; if (s_cyc !== 1'b1 || s_addr !== 32'h20) begin
            errors++; $display("FAIL to_next_grant cyc=%b addr=%h want 1/20", s_cyc, s_addr);
        end
        clear_inputs();
        tick();
        tick();
    endtask
`else
    // Reference model: grant holder, round-robin pointer and outstanding count.
    task automatic test_random();
        bit           mg;
        int           mgnt, mrr, mout;
        logic [N-1:0] exp_stall, exp_ack, exp_err;
        logic         exp_cyc, exp_stb, acc, rsp, fnd;
        do_reset();
        mg = 0; mgnt = 0; mrr = 0; mout = 0;
        for (int c = 0; c < 600; c++) begin
            for (int j = 0; j < N; j++) begin
                if (!m_cyc[j]) m_cyc[j] = ($urandom_range(3) == 0);
                else if ($urandom_range(7) == 0) m_cyc[j] = 1'b0;
                m_stb[j]    = m_cyc[j] && ($urandom_range(1) == 1);
                m_we[j]     = 1'($urandom);
                m_addr[j]   = $urandom;
                m_data_m[j] = $urandom;
                m_sel[j]    = 4'($urandom);
            end
            s_stall  = ($urandom_range(3) == 0);
            s_ack    = ($urandom_range(1) == 0);
            s_err    = ($urandom_range(15) == 0);
            s_data_s = $urandom;
            #2;
            exp_cyc = mg ? m_cyc[mgnt] : 1'b0;
            exp_stb = mg ? m_stb[mgnt] : 1'b0;
            exp_stall = '1; exp_ack = '0; exp_err = '0;
            if (mg) begin
                exp_stall[mgnt] = s_stall; exp_ack[mgnt] = s_ack; exp_err[mgnt] = s_err;
            end
            checks++; if (s_cyc !== exp_cyc || s_stb !== exp_stb) begin
                errors++; $display("FAIL rnd_cyc_stb @%0d got %b%b want %b%b", c, s_cyc, s_stb, exp_cyc, exp_stb);
            end
            checks++; if (m_stall !== exp_stall || m_ack !== exp_ack || m_err !== exp_err) begin
                errors++; $display("FAIL rnd_resp @%0d got %b/%b/%b want %b/%b/%b", c, m_stall, m_ack, m_err,
                                   exp_stall, exp_ack, exp_err);
            end
            checks++; if (m_data_s[0] !== s_data_s || m_data_s[1] !== s_data_s) begin
                errors++; $display("FAIL rnd_rdata @%0d got %h/%h want %h", c, m_data_s[0], m_data_s[1], s_data_s);
            end
            if (mg) begin
                checks++; if (s_addr !== m_addr[mgnt] || s_data_m !== m_data_m[mgnt] ||
                              s_sel !== m_sel[mgnt] || s_we !== m_we[mgnt]) begin
                    errors++; $display("FAIL rnd_pass @%0d addr %h want %h", c, s_addr, m_addr[mgnt]);
                end
            end
            checks++; if (int'(dut.outstanding_q) != mout) begin
                errors++; $display("FAIL rnd_outstanding @%0d got %0d want %0d", c, dut.outstanding_q, mout);
            end
            if (!mg) begin
                fnd = 1'b0;
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (mrr + k) % N;
                    if (!fnd && m_cyc[idx]) begin fnd = 1'b1; mg = 1; mgnt = idx; end
                end
            end else if (!m_cyc[mgnt]) begin
                mg = 0; mrr = (mgnt + 1) % N; mout = 0;
            end else begin
                acc = m_stb[mgnt] && !s_stall;
                rsp = s_ack || s_err;
                if (acc && !rsp) mout++;
                else if (!acc && rsp && mout > 0) mout--;
            end
            tick();
        end
        clear_inputs();
        tick();
        tick();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_pipelined();
        test_late_ack();
        test_midburst_reset();
`ifdef WB_ARBITER_TIMEOUT_EN
        test_timeout();
`else
        test_random();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
